// File: rtl/traffic_light_timed_pkg.sv
// Shared phase encoding, lamp codes and the phase-to-lamp decode for the timed traffic-light controller.
package traffic_light_timed_pkg;

    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_Y   = 3'd1,
        ALL_R1   = 3'd2,
        SIDE_G   = 3'd3,
        SIDE_Y   = 3'd4,
        ALL_R2   = 3'd5,
        PED_WALK = 3'd6
    } phase_e;

    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    typedef struct packed {
        logic [2:0] mainLamp;
        logic [2:0] sideLamp;
        logic       pedWalk;
    } lamps_t;

    // Lamp pattern shown while in a given phase; anything not green/yellow is red.
    function automatic lamps_t lampsFor(phase_e p);
        lamps_t l;
        l = '{mainLamp: LAMP_R, sideLamp: LAMP_R, pedWalk: 1'b0};
        case (p)
            MAIN_G:   l.mainLamp = LAMP_G;
            MAIN_Y:   l.mainLamp = LAMP_Y;
            SIDE_G:   l.sideLamp = LAMP_G;
            SIDE_Y:   l.sideLamp = LAMP_Y;
            PED_WALK: l.pedWalk  = 1'b1;
            default:  ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_timed_phase_timer.sv
// Per-phase down counter: reloads on phase entry, decrements on ticks and holds at zero.
module traffic_light_timed_phase_timer #(
    parameter int unsigned    CW        = 4,
    parameter logic [CW-1:0]  RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] loadVal,
    input  logic          tick,
    output logic          done_c
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= RESET_VAL;
        end else if (load) begin
            cnt <= loadVal;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/traffic_light_timed.sv
// Two-road traffic-light controller with per-phase tick durations, latched side/ped demand and optional actuated main green.
module traffic_light_timed
    import traffic_light_timed_pkg::*;
#(
    parameter int unsigned T_MAIN_G = 8,
    parameter int unsigned T_MAIN_Y = 2,
    parameter int unsigned T_ALL_R  = 1,
    parameter int unsigned T_SIDE_G = 4,
    parameter int unsigned T_SIDE_Y = 2,
    parameter int unsigned T_PED    = 6,
    parameter bit          ACTUATED = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       ped_button,
    input  logic       side_sensor,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic       side_pending,
    output logic       new_cycle,
    output logic [2:0] phase
);

    localparam int unsigned T_MAX01 = (T_MAIN_G > T_MAIN_Y) ? T_MAIN_G : T_MAIN_Y;
    localparam int unsigned T_MAX23 = (T_ALL_R  > T_SIDE_G) ? T_ALL_R  : T_SIDE_G;
    localparam int unsigned T_MAX45 = (T_SIDE_Y > T_PED)    ? T_SIDE_Y : T_PED;
    localparam int unsigned T_MAXA  = (T_MAX01  > T_MAX23)  ? T_MAX01  : T_MAX23;
    localparam int unsigned T_MAX   = (T_MAXA   > T_MAX45)  ? T_MAXA   : T_MAX45;
    localparam int unsigned CW      = $clog2(T_MAX + 1);

    phase_e        stateQ;
    phase_e        nextState;
    phase_e        succ;
    logic          gate;
    logic          illegal;
    logic          take;
    logic          timerDone;
    logic [CW-1:0] loadVal;

    // Counter reload value for a phase: it runs T-1 down to 0, giving T ticks.
    function automatic logic [CW-1:0] durationOf(phase_e p);
        logic [CW-1:0] d;
        case (p)
            MAIN_Y:         d = CW'(T_MAIN_Y - 1);
            ALL_R1, ALL_R2: d = CW'(T_ALL_R - 1);
            SIDE_G:         d = CW'(T_SIDE_G - 1);
            SIDE_Y:         d = CW'(T_SIDE_Y - 1);
            PED_WALK:       d = CW'(T_PED - 1);
            default:        d = CW'(T_MAIN_G - 1);
        endcase
        return d;
    endfunction

    // Successor phase and whether the expiry of the current phase may advance it.
    always_comb begin
        succ    = MAIN_G;
        gate    = 1'b1;
        illegal = 1'b0;
        case (stateQ)
            MAIN_G: begin
                succ = MAIN_Y;
                gate = (ACTUATED == 1'b0) || side_pending || ped_pending;
            end
            MAIN_Y:   succ = ALL_R1;
            ALL_R1:   succ = SIDE_G;
            SIDE_G:   succ = SIDE_Y;
            SIDE_Y:   succ = ALL_R2;
            ALL_R2:   succ = ped_pending ? PED_WALK : MAIN_G;
            PED_WALK: succ = MAIN_G;
            default:  illegal = 1'b1;
        endcase
        // An unused encoding recovers immediately, independent of en.
        take      = illegal || (en && timerDone && gate);
        nextState = take ? succ : stateQ;
        loadVal   = durationOf(nextState);
    end

    traffic_light_timed_phase_timer #(
        .CW        (CW),
        .RESET_VAL (CW'(T_MAIN_G - 1))
    ) uTimer (
        .clk     (clk),
        .reset   (reset),
        .load    (take),
        .loadVal (loadVal),
        .tick    (en),
        .done_c  (timerDone)
    );

    // Requests are cleared on entry to the phase serving them; clear beats a same-edge set.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ       <= MAIN_G;
            ped_pending  <= 1'b0;
            side_pending <= 1'b0;
            new_cycle    <= 1'b0;
            main_lamp    <= LAMP_G;
            side_lamp    <= LAMP_R;
            ped_walk     <= 1'b0;
        end else begin
            stateQ       <= nextState;
            ped_pending  <= !(take && (nextState == PED_WALK)) &&
                            (ped_pending || (ped_button && (stateQ != PED_WALK)));
            side_pending <= !(take && (nextState == SIDE_G)) &&
                            (side_pending || (side_sensor && (stateQ != SIDE_G)));
            new_cycle    <= take && (nextState == MAIN_G) &&
                            ((stateQ == ALL_R2) || (stateQ == PED_WALK));
            {main_lamp, side_lamp, ped_walk} <= lampsFor(nextState);
        end
    end

    assign phase = stateQ;

endmodule
